// File: rtl/udma_qspi_slave_if.sv
// Byte stream bundle between the QSPI target and the uDMA side.
//   rx_data/rx_valid/rx_ready : bytes received from the SPI master
//   tx_data/tx_valid/tx_ready : bytes to be sent back to the SPI master
// slave modport is the QSPI target, master modport is the uDMA side.
`timescale 1ns/1ps
interface udma_qspi_slave_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport slave  (output rx_data, rx_valid, tx_ready,
                  input  rx_ready, tx_data, tx_valid);
  modport master (input  rx_data, rx_valid, tx_ready,
                  output rx_ready, tx_data, tx_valid);
endinterface

// File: rtl/udma_qspi_slave.sv
// Quad-SPI target (mode 0 only), oversampled in the sys_clk_i domain.
// Decodes a one-byte command, then streams write data to strm.rx_* or
// shifts strm.tx_* bytes out on SDO1 (single) or SDO3..0 (quad).
// Ports:
//   sys_clk_i, rstn_i          clock, async active-low reset
//   spi_sck_i, spi_csn_i       SPI clock / chip select from pads
//   spi_sdi*_i, spi_sdo*_o     data lines in / out
//   spi_oen*_o                 pad output enable, active-low
//   strm                       rx/tx byte streams (slave modport)
//   cmd_o, byte_cnt_o          last command, data bytes in transaction
//   busy_o, eot_o              CS asserted, end-of-transaction pulse
//   overrun_o, underrun_o      sticky errors, cleared by clr_i
//
// state  | meaning
// IDLE   | CS high, pads tri-stated
// CMD    | shifting in the command byte on SDI0
// WR1    | receiving bytes on SDI0
// WR4    | receiving nibbles on SDI3..0
// RD1    | sending bytes on SDO1
// RD4    | sending nibbles on SDO3..0
// IGNORE | unknown command, wait for CS high
`timescale 1ns/1ps
module udma_qspi_slave #(
  parameter int SCK_RATIO = 8
) (
  input  logic        sys_clk_i,
  input  logic        rstn_i,
  input  logic        spi_sck_i,
  input  logic        spi_csn_i,
  input  logic        spi_sdi0_i,
  input  logic        spi_sdi1_i,
  input  logic        spi_sdi2_i,
  input  logic        spi_sdi3_i,
  output logic        spi_sdo0_o,
  output logic        spi_sdo1_o,
  output logic        spi_sdo2_o,
  output logic        spi_sdo3_o,
  output logic        spi_oen0_o,
  output logic        spi_oen1_o,
  output logic        spi_oen2_o,
  output logic        spi_oen3_o,
  output logic [7:0]  cmd_o,
  output logic [15:0] byte_cnt_o,
  output logic        busy_o,
  output logic        eot_o,
  output logic        overrun_o,
  output logic        underrun_o,
  input  logic        clr_i,
  udma_qspi_slave_if.slave strm
);

  if (SCK_RATIO < 4) begin : g_ratio_chk
    $error("SCK_RATIO too small for the pin oversampling latency");
  end

  typedef enum logic [2:0] {IDLE, CMD, WR1, WR4, RD1, RD4, IGNORE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      sck_sync_q, sck_sync_d, csn_sync_q, csn_sync_d;
  logic [2:0][3:0] sdi_sync_q, sdi_sync_d;
  logic            sck_rise_q, sck_rise_d, sck_fall_q, sck_fall_d;
  logic            csn_rise_q, csn_rise_d, csn_fall_q, csn_fall_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d, tx_shift_q, tx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d, cmd_q, cmd_d;
  logic            rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d, eot_q, eot_d;
  logic            overrun_q, overrun_d, underrun_q, underrun_d;
  logic [15:0]     byte_cnt_q, byte_cnt_d;
  logic [3:0]      sdo_q, sdo_d, oen_q, oen_d;

  logic [3:0] sdi;
  logic [7:0] in_byte;
  logic       wr_done, rd_done;

  // Data lines are taken from the same pipeline stage as the edge pulses.
  assign sdi = sdi_sync_q[2];

  always_comb begin
    sck_sync_d = {sck_sync_q[1:0], spi_sck_i};
    csn_sync_d = {csn_sync_q[1:0], spi_csn_i};
    sdi_sync_d = {sdi_sync_q[1:0], {spi_sdi3_i, spi_sdi2_i, spi_sdi1_i, spi_sdi0_i}};
    sck_rise_d = sck_sync_q[1] & ~sck_sync_q[2];
    sck_fall_d = ~sck_sync_q[1] & sck_sync_q[2];
    csn_rise_d = csn_sync_q[1] & ~csn_sync_q[2];
    csn_fall_d = ~csn_sync_q[1] & csn_sync_q[2];

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    cmd_d      = cmd_q;
    byte_cnt_d = byte_cnt_q;
    sdo_d      = sdo_q;
    oen_d      = oen_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    tx_ready_d = 1'b0;
    eot_d      = 1'b0;
    wr_done    = 1'b0;
    rd_done    = 1'b0;
    in_byte    = {shift_q[6:0], sdi[0]};

    if (rx_valid_q && strm.rx_ready) rx_valid_d = 1'b0;
    if (clr_i) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end

    // tx_ready was high during this cycle: take the next byte (or 0x00).
    if (tx_ready_q && (state_q == RD1 || state_q == RD4)) begin
      if (strm.tx_valid) begin
        tx_shift_d = strm.tx_data;
      end else begin
        tx_shift_d = 8'h00;
        underrun_d = 1'b1;
      end
    end

    if (csn_rise_q && state_q != IDLE) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      oen_d     = 4'hF;
      sdo_d     = 4'h0;
      eot_d     = 1'b1;
    end else if (csn_fall_q) begin
      state_d    = CMD;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
    end else begin
      case (state_q)
        CMD: if (sck_rise_q) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            cmd_d = in_byte;
            case (in_byte)
              8'h02: state_d = WR1;
              8'h32: state_d = WR4;
              8'h03: begin
                state_d    = RD1;
                oen_d      = 4'b1101;
                tx_ready_d = 1'b1;
              end
              8'h6B: begin
                state_d    = RD4;
                oen_d      = 4'b0000;
                tx_ready_d = 1'b1;
              end
              default: state_d = IGNORE;
            endcase
          end
        end
        WR1: if (sck_rise_q) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          wr_done   = (bit_cnt_q == 3'd7);
        end
        WR4: if (sck_rise_q) begin
          in_byte   = {shift_q[3:0], sdi};
          shift_d   = in_byte;
          bit_cnt_d = (bit_cnt_q == 3'd1) ? 3'd0 : bit_cnt_q + 3'd1;
          wr_done   = (bit_cnt_q == 3'd1);
        end
        RD1: begin
          if (sck_fall_q) begin
            sdo_d      = {2'b00, tx_shift_q[7], 1'b0};
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
          if (sck_rise_q) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            rd_done   = (bit_cnt_q == 3'd7);
          end
        end
        RD4: begin
          if (sck_fall_q) begin
            sdo_d      = tx_shift_q[7:4];
            tx_shift_d = {tx_shift_q[3:0], 4'h0};
          end
          if (sck_rise_q) begin
            bit_cnt_d = (bit_cnt_q == 3'd1) ? 3'd0 : bit_cnt_q + 3'd1;
            rd_done   = (bit_cnt_q == 3'd1);
          end
        end
        default: ;
      endcase
    end

    if (wr_done) begin
      if (!rx_valid_q) begin
        rx_data_d  = in_byte;
        rx_valid_d = 1'b1;
        if (byte_cnt_q != 16'hFFFF) byte_cnt_d = byte_cnt_q + 16'd1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (rd_done) begin
      tx_ready_d = 1'b1;
      if (byte_cnt_q != 16'hFFFF) byte_cnt_d = byte_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      sck_sync_q <= 3'b000;
      csn_sync_q <= 3'b111;
      sdi_sync_q <= '0;
      sck_rise_q <= 1'b0;
      sck_fall_q <= 1'b0;
      csn_rise_q <= 1'b0;
      csn_fall_q <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      eot_q      <= 1'b0;
      cmd_q      <= '0;
      byte_cnt_q <= '0;
      sdo_q      <= 4'h0;
      oen_q      <= 4'hF;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_sync_q <= sck_sync_d;
      csn_sync_q <= csn_sync_d;
      sdi_sync_q <= sdi_sync_d;
      sck_rise_q <= sck_rise_d;
      sck_fall_q <= sck_fall_d;
      csn_rise_q <= csn_rise_d;
      csn_fall_q <= csn_fall_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      eot_q      <= eot_d;
      cmd_q      <= cmd_d;
      byte_cnt_q <= byte_cnt_d;
      sdo_q      <= sdo_d;
      oen_q      <= oen_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign {spi_sdo3_o, spi_sdo2_o, spi_sdo1_o, spi_sdo0_o} = sdo_q;
  assign {spi_oen3_o, spi_oen2_o, spi_oen1_o, spi_oen0_o} = oen_q;
  assign strm.rx_data  = rx_data_q;
  assign strm.rx_valid = rx_valid_q;
  assign strm.tx_ready = tx_ready_q;
  assign cmd_o         = cmd_q;
  assign byte_cnt_o    = byte_cnt_q;
  assign busy_o        = ~csn_sync_q[1];
  assign eot_o         = eot_q;
  assign overrun_o     = overrun_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_udma_qspi_slave.sv
`timescale 1ns/1ps
module tb_udma_qspi_slave;
  localparam int HALF = 8;  // sys_clk cycles per SCK half period

  logic clk = 1'b0;
  logic rstn, sck, csn, clr;
  logic sdi0, sdi1, sdi2, sdi3;
  logic sdo0, sdo1, sdo2, sdo3, oen0, oen1, oen2, oen3;
  logic [7:0]  cmd;
  logic [15:0] byte_cnt;
  logic busy, eot, overrun, underrun;
  logic [3:0] sdo_v, oen_v;

  udma_qspi_slave_if strm ();

  always #5 clk = ~clk;

  udma_qspi_slave #(.SCK_RATIO(8)) dut (
    .sys_clk_i(clk), .rstn_i(rstn),
    .spi_sck_i(sck), .spi_csn_i(csn),
    .spi_sdi0_i(sdi0), .spi_sdi1_i(sdi1), .spi_sdi2_i(sdi2), .spi_sdi3_i(sdi3),
    .spi_sdo0_o(sdo0), .spi_sdo1_o(sdo1), .spi_sdo2_o(sdo2), .spi_sdo3_o(sdo3),
    .spi_oen0_o(oen0), .spi_oen1_o(oen1), .spi_oen2_o(oen2), .spi_oen3_o(oen3),
    .cmd_o(cmd), .byte_cnt_o(byte_cnt), .busy_o(busy), .eot_o(eot),
    .overrun_o(overrun), .underrun_o(underrun), .clr_i(clr),
    .strm(strm.slave)
  );

  assign sdo_v = {sdo3, sdo2, sdo1, sdo0};
  assign oen_v = {oen3, oen2, oen1, oen0};

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  int   tx_rdy_cnt = 0;
  int   eot_cnt    = 0;
  logic oen_watch  = 1'b0;
  logic oen_bad    = 1'b0;

  always @(posedge clk) begin
    if (strm.rx_valid && strm.rx_ready) rx_q.push_back(strm.rx_data);
    if (strm.tx_ready) tx_rdy_cnt++;
    if (eot) eot_cnt++;
    if (oen_watch && oen_v !== 4'hF) oen_bad = 1'b1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q);
    {sdi3, sdi2, sdi1, sdi0} = d;
    repeat (HALF) @(negedge clk);
    q   = sdo_v;
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic cs_low();
    csn = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    csn = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send1(input logic [7:0] b);
    logic [3:0] q;
    for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]}, q);
  endtask

  task automatic read1(output logic [7:0] r);
    logic [3:0] q;
    for (int i = 7; i >= 0; i--) begin
      sck_cycle(4'h0, q);
      r[i] = q[1];
    end
  endtask

  task automatic read4(output logic [7:0] r);
    logic [3:0] q;
    sck_cycle(4'h0, q);
    r[7:4] = q;
    sck_cycle(4'h0, q);
    r[3:0] = q;
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] b;
    logic [3:0] q;
    int eot0, rdy0;

    rstn = 1'b0; csn = 1'b1; sck = 1'b0; clr = 1'b0;
    {sdi3, sdi2, sdi1, sdi0} = 4'h0;
    strm.rx_ready = 1'b0; strm.tx_valid = 1'b0; strm.tx_data = 8'h00;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_sdo", 16'(sdo_v), 16'h0);
    check("rst_oen", 16'(oen_v), 16'hF);
    check("rst_rx_valid", 16'(strm.rx_valid), 16'h0);
    check("rst_rx_data", 16'(strm.rx_data), 16'h0);
    check("rst_tx_ready", 16'(strm.tx_ready), 16'h0);
    check("rst_eot", 16'(eot), 16'h0);
    check("rst_cmd", 16'(cmd), 16'h0);
    check("rst_byte_cnt", byte_cnt, 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_flags", 16'({overrun, underrun}), 16'h0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // single write
    strm.rx_ready = 1'b1; rx_q.delete(); eot0 = eot_cnt;
    oen_bad = 1'b0; oen_watch = 1'b1;
    cs_low();
    check("wr1_busy", 16'(busy), 16'h1);
    send1(8'h02); send1(8'hA5); send1(8'h3C);
    cs_high();
    oen_watch = 1'b0;
    check("wr1_rx_count", 16'(rx_q.size()), 16'd2);
    if (rx_q.size() == 2) begin
      check("wr1_rx0", 16'(rx_q[0]), 16'h00A5);
      check("wr1_rx1", 16'(rx_q[1]), 16'h003C);
    end
    check("wr1_byte_cnt", byte_cnt, 16'd2);
    check("wr1_cmd", 16'(cmd), 16'h0002);
    check("wr1_eot", 16'(eot_cnt - eot0), 16'd1);
    check("wr1_oen_tristate", 16'(oen_bad), 16'h0);
    check("wr1_busy_end", 16'(busy), 16'h0);

    // quad write
    rx_q.delete();
    cs_low();
    send1(8'h32);
    sck_cycle(4'h1, q); sck_cycle(4'h2, q); sck_cycle(4'h3, q); sck_cycle(4'h4, q);
    cs_high();
    check("wr4_rx_count", 16'(rx_q.size()), 16'd2);
    if (rx_q.size() == 2) begin
      check("wr4_rx0", 16'(rx_q[0]), 16'h0012);
      check("wr4_rx1", 16'(rx_q[1]), 16'h0034);
    end
    check("wr4_cmd", 16'(cmd), 16'h0032);
    check("wr4_byte_cnt", byte_cnt, 16'd2);

    // single read
    strm.tx_data = 8'h96; strm.tx_valid = 1'b1; rdy0 = tx_rdy_cnt;
    cs_low();
    send1(8'h03);
    strm.tx_data = 8'h0F;
    check("rd1_oen", 16'(oen_v), 16'hD);
    read1(r);
    check("rd1_byte0", 16'(r), 16'h0096);
    check("rd1_tx_ready_pulses", 16'(tx_rdy_cnt - rdy0), 16'd2);
    strm.tx_data = 8'h5A;
    read1(r);
    check("rd1_byte1", 16'(r), 16'h000F);
    check("rd1_byte_cnt", byte_cnt, 16'd2);
    check("rd1_underrun", 16'(underrun), 16'h0);
    check("rd1_cmd", 16'(cmd), 16'h0003);
    cs_high();
    check("rd1_oen_end", 16'(oen_v), 16'hF);
    check("rd1_sdo_end", 16'(sdo_v), 16'h0);

    // quad read with underrun
    strm.tx_data = 8'hC3; strm.tx_valid = 1'b1; eot0 = eot_cnt;
    cs_low();
    send1(8'h6B);
    strm.tx_valid = 1'b0;
    check("rd4_oen", 16'(oen_v), 16'h0);
    read4(r);
    check("rd4_byte0", 16'(r), 16'h00C3);
    read4(r);
    check("rd4_byte1", 16'(r), 16'h0000);
    check("rd4_underrun", 16'(underrun), 16'h1);
    check("rd4_byte_cnt", byte_cnt, 16'd2);
    cs_high();
    check("rd4_eot", 16'(eot_cnt - eot0), 16'd1);
    check("rd4_underrun_sticky", 16'(underrun), 16'h1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("rd4_underrun_clr", 16'(underrun), 16'h0);

    // overrun, with write latency on the first byte
    strm.rx_ready = 1'b0; rx_q.delete();
    cs_low();
    send1(8'h02);
    b = 8'h11;
    for (int i = 7; i >= 1; i--) sck_cycle({3'b000, b[i]}, q);
    sdi0 = b[0];
    repeat (HALF) @(negedge clk);
    sck = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("ovr_latency_early", 16'(strm.rx_valid), 16'h0);
    @(posedge clk);
    #1 check("ovr_latency_valid", 16'(strm.rx_valid), 16'h1);
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
    send1(8'h22); send1(8'h33);
    check("ovr_rx_data", 16'(strm.rx_data), 16'h0011);
    check("ovr_rx_valid", 16'(strm.rx_valid), 16'h1);
    check("ovr_flag", 16'(overrun), 16'h1);
    check("ovr_byte_cnt", byte_cnt, 16'd1);
    cs_high();
    check("ovr_byte_cnt_hold", byte_cnt, 16'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("ovr_clr", 16'(overrun), 16'h0);
    strm.rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    rx_q.delete();

    // abort after 5 data bits, then a clean byte
    eot0 = eot_cnt;
    cs_low();
    send1(8'h02);
    for (int i = 0; i < 5; i++) sck_cycle(4'h1, q);
    cs_high();
    check("abort_no_rx", 16'(rx_q.size()), 16'd0);
    check("abort_byte_cnt", byte_cnt, 16'd0);
    check("abort_eot", 16'(eot_cnt - eot0), 16'd1);
    cs_low();
    send1(8'h02); send1(8'h5A);
    cs_high();
    check("abort_next_count", 16'(rx_q.size()), 16'd1);
    if (rx_q.size() == 1) check("abort_next_byte", 16'(rx_q[0]), 16'h005A);

    // unknown command
    rx_q.delete(); eot0 = eot_cnt; rdy0 = tx_rdy_cnt;
    strm.tx_valid = 1'b1;
    oen_bad = 1'b0; oen_watch = 1'b1;
    cs_low();
    send1(8'h9F); send1(8'hAA);
    cs_high();
    oen_watch = 1'b0;
    check("ign_cmd", 16'(cmd), 16'h009F);
    check("ign_no_rx", 16'(rx_q.size()), 16'd0);
    check("ign_no_tx_ready", 16'(tx_rdy_cnt - rdy0), 16'd0);
    check("ign_eot", 16'(eot_cnt - eot0), 16'd1);
    check("ign_oen", 16'(oen_bad), 16'h0);
    check("ign_byte_cnt", byte_cnt, 16'd0);

    // reset in the middle of a read
    strm.tx_data = 8'hFF; strm.tx_valid = 1'b1;
    cs_low();
    send1(8'h03);
    for (int i = 0; i < 3; i++) sck_cycle(4'h0, q);
    repeat (5) @(negedge clk);
    check("rst_mid_sdo_before", 16'(sdo_v), 16'h2);
    eot0 = eot_cnt;
    rstn = 1'b0;
    #1;
    check("rst_mid_sdo", 16'(sdo_v), 16'h0);
    check("rst_mid_oen", 16'(oen_v), 16'hF);
    check("rst_mid_cmd", 16'(cmd), 16'h0);
    check("rst_mid_busy", 16'(busy), 16'h0);
    check("rst_mid_tx_ready", 16'(strm.tx_ready), 16'h0);
    csn = 1'b1;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check("rst_mid_no_eot", 16'(eot_cnt - eot0), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
